gate_arbiter: RTL
=================

# gate_arbiter

Round-robin arbiter and sequencer that shares one registered bitwise logic unit (NAND/NOR/AND/XOR) among N requesters. Each requester presents operands and an opcode under a req/done handshake. The arbiter grants one requester at a time, runs the shared unit, and returns the result with a one-cycle done pulse. It sits between the Level-1 gate exercises and any block that needs gate evaluation on demand.

## Interface
- N_REQ, default 4: number of requesters; minimum 2.
- WIDTH, default 8: operand and result width in bits; the unit operates bitwise.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- req  input  N_REQ  per-requester request level.
- a_in  input  N_REQ*WIDTH  operand A; requester k owns slice [k*WIDTH +: WIDTH].
- b_in  input  N_REQ*WIDTH  operand B; same slicing as a_in.
- op_in  input  N_REQ*2  opcode; requester k owns slice [2k +: 2]. Encoding: 00 NAND, 01 NOR, 10 AND, 11 XOR.
- gnt  output  N_REQ  one-hot grant, held for the whole transaction.
- y_out  output  WIDTH  result of the last completed transaction.
- done  output  N_REQ  one-hot pulse, one cycle, to the granted requester.
- busy  output  1  high in every state except IDLE.

## Operation
- FSM states and transitions:
  - IDLE: waits for a request. If req is nonzero, go to EXEC; otherwise stay in IDLE.
  - EXEC: always goes to DONE.
  - DONE: always goes to IDLE.
- Arbitration (IDLE):
  - Search req starting at index ptr and wrap modulo N_REQ. The first set bit wins (index w).
  - Register gnt = one-hot(w).
  - Latch a_in, b_in and op_in slices of w into a_r, b_r and op_r.
- EXEC: the shared unit computes f(op_r, a_r, b_r) bitwise. At the edge, register the result into y_out and set done[w].
- DONE: done[w] = 1 for this cycle only. At the edge:
  - clear gnt and done;
  - set ptr = (w+1) mod N_REQ.
- Handshake rules:
  - A requester holds req and its operands stable until it sees done.
  - Operands are latched in IDLE, so later changes to a requester's operands do not affect its transaction.
  - If req[w] drops after the grant, the transaction still completes and done still pulses.
  - If req[k] is still high in the IDLE cycle after done, it counts as a new request under the advanced pointer.
- Requests arriving while busy are not lost. They are evaluated at the next IDLE cycle.
- y_out holds its value until the next EXEC edge. Results are valid to read only in the done cycle and after it.
- Unit arithmetic:
  - NAND = ~(a&b), NOR = ~(a|b), AND = a&b, XOR = a^b, all at full WIDTH.
  - No carry and no width growth.

## Timing
- Latency: req sampled in IDLE at cycle 0, gnt high from cycle 1, done high in cycle 2, back to IDLE in cycle 3.
- Throughput: one transaction per 3 cycles under continuous requests.
- Reset values: state=IDLE, ptr=0, gnt=0, done=0, y_out=0, busy=0, and all latched operands 0.
- Reset takes effect at any cycle, including EXEC or DONE. The aborted transaction produces no done pulse, and the next arbitration starts from ptr=0.
- Simultaneous requests: exactly one grant. The order is round-robin from ptr, so with all requesters continuously asserting req, grants follow 0,1,2,3,0,…
- Single persistent requester: it is granted every 3 cycles regardless of ptr.
- gnt and done are never multi-hot. done is never asserted outside DONE.

## Structure
- Package gate_pkg holds:
  - opcode localparams OP_NAND=2'b00, OP_NOR=2'b01, OP_AND=2'b10, OP_XOR=2'b11;
  - FSM state encoding S_IDLE, S_EXEC, S_DONE (2 bits).
- Sub-module gate_unit is purely combinational, parameterised by WIDTH, with ports op, a, b, y. The arbiter instantiates it exactly once, which makes the sharing explicit.
- The round-robin search is a loop over 2*N_REQ candidate indices reduced modulo N_REQ, kept in the top module.

## Test plan
- Reset and idle:
  - Stimulus: assert rst for 2 cycles, req=0.
  - Required: gnt=0, done=0, y_out=0, busy=0; no state change with req=0.
- Single NAND:
  - Stimulus: req=0001, a=8'hF0, b=8'hCC, op=00.
  - Required: gnt=0001 in cycle 1, done=0001 in cycle 2, y_out=8'h3F; busy low in cycle 3.
- Round-robin fairness:
  - Stimulus: req=1111 held continuously.
  - Required: done order 0,1,2,3,0 at cycles 2,5,8,11,14.
- All opcodes:
  - Stimulus: requester 2 with a=8'hAA, b=8'h0F, each opcode in turn.
  - Required: NAND=8'hF5, NOR=8'h50, AND=8'h0A, XOR=8'hA5.
- Request drop and operand change:
  - Stimulus: requester 1 drops req and changes a_in in EXEC.
  - Required: done[1] still pulses, with y_out computed from the originally latched operands.
- Reset mid-op:
  - Stimulus: assert rst during EXEC, with req=0100 held after reset.
  - Required: no done from the aborted op; ptr=0; requester 2 granted 1 cycle after rst release.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared definitions for the gate arbiter: opcode encoding and FSM states.
package gate_pkg;

  localparam logic [1:0] OP_NAND = 2'b00;
  localparam logic [1:0] OP_NOR  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_XOR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gate_unit.sv
// Shared bitwise logic unit: NAND / NOR / AND / XOR at full width, no carry.
module gate_unit
  import gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Select the bitwise function named by the opcode.
  always_comb begin
    y = '0;
    case (op)
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/gate_arbiter.sv
// Round-robin arbiter that shares a single gate_unit among N_REQ requesters.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no transaction; pick a requester round-robin from ptr
// EXEC   | grant held, shared unit evaluates latched operands
// DONE   | done pulse to the granted requester, result on y_out
module gate_arbiter
  import gate_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  input  logic [N_REQ*2-1:0]     op_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       y_out,
  output logic [N_REQ-1:0]       done,
  output logic                   busy
);

  localparam int PW = $clog2(N_REQ);

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    w_r;
  logic [PW-1:0]    w_sel;
  logic             found;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] y_unit;

  // Scan two laps of candidates so that starting at ptr and wrapping past
  // the top index is just a contiguous walk; the first set request wins.
  always_comb begin
    found = 1'b0;
    w_sel = '0;
    for (int i = 0; i < 2 * N_REQ; i++) begin
      if (!found && (i >= int'(ptr)) && req[i % N_REQ]) begin
        found = 1'b1;
        w_sel = PW'(i % N_REQ);
      end
    end
  end

  gate_unit #(
    .WIDTH(WIDTH)
  ) u_gate_unit (
    .op(op_r),
    .a (a_r),
    .b (b_r),
    .y (y_unit)
  );

  assign busy = (state != S_IDLE);

  // Sequencer: arbitrate and latch in IDLE, capture result in EXEC, release in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= '0;
      w_r   <= '0;
      gnt   <= '0;
      done  <= '0;
      y_out <= '0;
      a_r   <= '0;
      b_r   <= '0;
      op_r  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            state <= S_EXEC;
            w_r   <= w_sel;
            gnt   <= N_REQ'(1) << w_sel;
            a_r   <= a_in[int'(w_sel)*WIDTH +: WIDTH];
            b_r   <= b_in[int'(w_sel)*WIDTH +: WIDTH];
            op_r  <= op_in[int'(w_sel)*2 +: 2];
          end
        end
        S_EXEC: begin
          y_out <= y_unit;
          done  <= gnt;
          state <= S_DONE;
        end
        S_DONE: begin
          gnt   <= '0;
          done  <= '0;
          ptr   <= (w_r == PW'(N_REQ - 1)) ? '0 : w_r + 1'b1;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          gnt   <= '0;
          done  <= '0;
        end
      endcase
    end
  end

endmodule
